// File: rtl/temporizador_param.sv
// Merged prescaler and timeout counter for the elevator door/overload timeouts.
// Define TEMPORIZADOR_AUTORELOAD_EN for periodic mode (reload on expiry, stay in RUN).
module temporizador_param #(
  parameter int unsigned CLK_DIV = 100000000,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             _clk_,
  input  logic             reset,
  input  logic             start_i,
  input  logic             restart_i,
  input  logic             pause_i,
  input  logic [CNT_W-1:0] duration_i,
  output logic             t_expired_o,
  output logic             expired_pulse_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] remaining_o
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PW-1:0]    presc, presc_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic             expired, expired_next;
  logic             pulse, pulse_next;
  logic             tick;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
  logic [CNT_W-1:0] reload, reload_next;
`endif

  always_comb tick = (state == RUN) && !pause_i && (presc == PRESC_LAST);

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_next     = state;
    presc_next     = presc;
    remaining_next = remaining;
    expired_next   = expired;
    pulse_next     = 1'b0;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
    reload_next    = reload;
`endif
    if (restart_i) begin
      // Restart wins over a simultaneous start: nothing is latched.
      state_next     = IDLE;
      presc_next     = '0;
      remaining_next = '0;
      expired_next   = 1'b0;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
      reload_next    = '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            presc_next     = '0;
            remaining_next = duration_i;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
            reload_next    = duration_i;
`endif
            if (duration_i == '0) begin
              state_next   = EXPIRED;
              expired_next = 1'b1;
              pulse_next   = 1'b1;
            end else begin
              state_next   = RUN;
            end
          end
        end
        RUN: begin
          if (!pause_i) begin
            presc_next = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
          end
          if (tick) begin
            if (remaining <= CNT_W'(1)) begin
              expired_next = 1'b1;
              pulse_next   = 1'b1;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
              remaining_next = reload;
`else
              remaining_next = '0;
              state_next     = EXPIRED;
`endif
            end else begin
              remaining_next = remaining - CNT_W'(1);
            end
          end
        end
        EXPIRED: ;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge _clk_ or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      remaining <= '0;
      expired   <= 1'b0;
      pulse     <= 1'b0;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
      reload    <= '0;
`endif
    end else begin
      state     <= state_next;
      presc     <= presc_next;
      remaining <= remaining_next;
      expired   <= expired_next;
      pulse     <= pulse_next;
`ifdef TEMPORIZADOR_AUTORELOAD_EN
      reload    <= reload_next;
`endif
    end
  end

  always_comb begin
    busy_o          = (state == RUN);
    t_expired_o     = expired;
    expired_pulse_o = pulse;
    tick_o          = tick;
    remaining_o     = remaining;
  end

endmodule

// File: tb/tb_temporizador_param.sv
// Randomized and directed bench for temporizador_param; reference model tracks
// elapsed unpaused cycles since start and derives all outputs arithmetically.
module tb_temporizador_param;

  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 4;

  logic             _clk_ = 1'b0;
  logic             reset;
  logic             start_i, restart_i, pause_i;
  logic [CNT_W-1:0] duration_i;
  logic             t_expired_o, expired_pulse_o, busy_o, tick_o;
  logic [CNT_W-1:0] remaining_o;

  temporizador_param #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    ._clk_          (_clk_),
    .reset          (reset),
    .start_i        (start_i),
    .restart_i      (restart_i),
    .pause_i        (pause_i),
    .duration_i     (duration_i),
    .t_expired_o    (t_expired_o),
    .expired_pulse_o(expired_pulse_o),
    .busy_o         (busy_o),
    .tick_o         (tick_o),
    .remaining_o    (remaining_o)
  );

  always #5 _clk_ = ~_clk_;

  int total = 0;
  int bad   = 0;

  typedef enum int {M_IDLE, M_RUN, M_EXP} mode_t;
  mode_t m_mode;
  int    m_dur, m_active;
  bit    m_flag, m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task model_clear();
    m_mode = M_IDLE; m_dur = 0; m_active = 0; m_flag = 0; m_pulse = 0;
  endtask

  // One clock edge of the reference: time is counted in unpaused RUN cycles.
  task model_edge();
    m_pulse = 0;
    if (restart_i) begin
      m_mode = M_IDLE; m_dur = 0; m_active = 0; m_flag = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start_i) begin
          m_dur    = int'(duration_i);
          m_active = 0;
          if (m_dur == 0) begin
            m_mode = M_EXP; m_flag = 1; m_pulse = 1;
          end else begin
            m_mode = M_RUN;
          end
        end
        M_RUN: if (!pause_i) begin
          m_active++;
          if (m_active % (m_dur * CLK_DIV) == 0) begin
            m_flag = 1; m_pulse = 1;
`ifndef TEMPORIZADOR_AUTORELOAD_EN
            m_mode = M_EXP;
`endif
          end
        end
        default: ;
      endcase
    end
  endtask

  task compare_all();
    int exp_rem;
    bit exp_tick;
    exp_rem  = (m_mode == M_RUN) ? m_dur - (m_active / CLK_DIV) % m_dur : 0;
    exp_tick = (m_mode == M_RUN) && !pause_i && (m_active % CLK_DIV == CLK_DIV - 1);
    check("busy",      busy_o,          (m_mode == M_RUN));
    check("t_expired", t_expired_o,     m_flag);
    check("pulse",     expired_pulse_o, m_pulse);
    check("tick",      tick_o,          exp_tick);
    check("remaining", remaining_o,     exp_rem);
  endtask

  task automatic step(input bit s, input bit r, input bit p, input int d);
    start_i    = s;
    restart_i  = r;
    pause_i    = p;
    duration_i = CNT_W'(d);
    @(posedge _clk_);
    model_edge();
    @(negedge _clk_);
    compare_all();
  endtask

  // Called at a negedge: async reset pulse that releases well before the next edge.
  task automatic async_reset_pulse();
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_busy",  busy_o,      0);
    check("rst_exp",   t_expired_o, 0);
    check("rst_rem",   remaining_o, 0);
    compare_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_i = 0; restart_i = 0; pause_i = 0; duration_i = '0;
    model_clear();
    repeat (2) @(negedge _clk_);
    check("reset_rem", remaining_o, 0);
    check("reset_pulse", expired_pulse_o, 0);
    compare_all();
    reset = 1'b0;

`ifndef TEMPORIZADOR_AUTORELOAD_EN
    // duration 3 from E0: ticks before E4/E8/E12, expiry at E12
    step(1, 0, 0, 3);
    check("busy_after_e0", busy_o, 1);
    for (int i = 1; i <= 11; i++) begin
      step(0, 0, 0, 0);
      if (i == 3) check("tick_before_e4", tick_o, 1);
    end
    check("no_exp_e11", t_expired_o, 0);
    step(0, 0, 0, 0);
    check("exp_e12", t_expired_o, 1);
    check("pulse_e12", expired_pulse_o, 1);
    step(0, 0, 0, 0);
    check("pulse_gone", expired_pulse_o, 0);
    step(0, 1, 0, 0);

    // zero duration, then start ignored while expired
    step(1, 0, 0, 0);
    check("zero_exp", t_expired_o, 1);
    check("zero_busy", busy_o, 0);
    step(1, 0, 0, 5);
    check("exp_no_restart", busy_o, 0);
    step(0, 1, 0, 0);

    // pause of 5 cycles delays expiry from E8 to E13
    step(1, 0, 0, 2);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      check("pause_frozen", remaining_o, 2);
    end
    for (int i = 7; i <= 12; i++) step(0, 0, 0, 0);
    check("pause_no_exp_e12", t_expired_o, 0);
    step(0, 0, 0, 0);
    check("pause_exp_e13", t_expired_o, 1);
    step(0, 1, 0, 0);
`else
    // periodic: pulses at E8, E16, E24, busy throughout
    step(1, 0, 0, 2);
    for (int i = 1; i <= 24; i++) begin
      step(0, 0, 0, 0);
      check("ar_busy", busy_o, 1);
      check("ar_pulse", expired_pulse_o, (i % 8 == 0));
    end
    step(0, 1, 0, 0);
`endif

    // restart beats start, in IDLE and in RUN
    step(1, 1, 0, 3);
    check("rs_idle_busy", busy_o, 0);
    step(1, 0, 0, 3);
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    check("rs_run_busy", busy_o, 0);
    check("rs_run_rem", remaining_o, 0);
    check("rs_run_exp", t_expired_o, 0);

    // async reset mid-run with remaining 2
    step(1, 0, 0, 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("pre_reset_rem", remaining_o, 2);
    async_reset_pulse();

    for (int n = 0; n < 3000; n++) begin
      int d;
      d = ($urandom % 8 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
      step(($urandom % 4 == 0), ($urandom % 40 == 0), ($urandom % 5 == 0), d);
      if ($urandom % 500 == 0) async_reset_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
